imem_fetch_unit: RTL and testbench

IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

---
 rtl/imem_fetch_unit.sv | 120 ++++++++++++
 tb/tb_imem_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit.sv
// Instruction memory fetch unit: valid/ready fetch port with a registered
// one-cycle response, fault detection, and a program-load mode.
module imem_fetch_unit #(
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 512,
  parameter int                 ADDR_W   = 32,
  parameter logic [DATA_W-1:0]  ERR_WORD = '0,
  localparam int                IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  output logic              load_mode,
  output logic [15:0]       err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    LOAD  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  rd_idx;
  logic              fault;
  logic              accept;
  logic              rsp_free;
  logic              prog_hit;

  // The full word address is range-checked so upper address bits never alias.
  assign word_addr = req_addr >> 2;
  assign fault     = (req_addr[1:0] != 2'b00) || (word_addr >= ADDR_W'(DEPTH));
  assign rd_idx    = req_addr[IDX_W+1:2];

  assign rsp_free  = ~rsp_valid | rsp_ready;
  assign req_ready = (state == RUN) & ~prog_en & rsp_free;
  assign accept    = req_valid & req_ready;
  assign prog_hit  = (state == LOAD) & prog_we &
                     ({1'b0, prog_addr} < (IDX_W+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (prog_hit) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  state_next = RUN;
      RUN: begin
        if (prog_en) begin
          state_next = rsp_free ? LOAD : DRAIN;
        end
      end
      DRAIN: begin
        if (!prog_en) begin
          state_next = RUN;
        end else if (rsp_ready) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (!prog_en) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      load_mode <= 1'b0;
    end else begin
      state     <= state_next;
      load_mode <= (state_next == LOAD);
    end
  end

  // Memory is only read for in-range, aligned fetches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= ERR_WORD;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= fault;
      rsp_data  <= fault ? ERR_WORD : mem[rd_idx];
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (accept && fault && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit: directed scenarios plus a random
// fetch phase checked against an array/transaction-level reference model.
module tb_imem_fetch_unit;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 512;
  localparam int          ADDR_W = 32;
  localparam int          IDX_W  = $clog2(DEPTH);
  localparam logic [31:0] ERRW   = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              prog_en;
  logic              prog_we;
  logic [IDX_W-1:0]  prog_addr;
  logic [DATA_W-1:0] prog_wdata;
  logic              load_mode;
  logic [15:0]       err_cnt;

  imem_fetch_unit #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ERR_WORD (ERRW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .prog_en    (prog_en),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .load_mode  (load_mode),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  // Reference model: word array plus one held-response slot.
  logic [31:0] mem_m [DEPTH];
  logic        m_held;
  logic [31:0] m_data;
  logic        m_err;
  int unsigned m_errcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  task automatic model_accept(input logic [31:0] a);
    m_held = 1'b1;
    m_err  = is_fault(a);
    m_data = m_err ? ERRW : mem_m[a >> 2];
    if (m_err && m_errcnt < 65535) m_errcnt++;
  endtask

  // One RUN-mode cycle: predict ready, clock, then compare the response slot.
  task automatic step(input logic v, input logic [31:0] a, input logic r);
    logic exp_rdy;
    req_valid = v;
    req_addr  = a;
    rsp_ready = r;
    prog_en   = 1'b0;
    prog_we   = 1'b0;
    #1;
    exp_rdy = !m_held || r;
    chk("req_ready", {31'b0, req_ready}, {31'b0, exp_rdy});
    tick();
    if (v && exp_rdy) model_accept(a);
    else if (r) m_held = 1'b0;
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_held});
    if (m_held) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
    end
    chk("err_cnt", {16'b0, err_cnt}, m_errcnt);
  endtask

  task automatic enter_load();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    prog_en   = 1'b1;
    prog_we   = 1'b0;
    tick();
    m_held = 1'b0;
    chk("load_mode_enter", {31'b0, load_mode}, 32'd1);
  endtask

  task automatic load_write(input int unsigned idx, input logic [31:0] d);
    prog_we    = 1'b1;
    prog_addr  = IDX_W'(idx);
    prog_wdata = d;
    tick();
    mem_m[idx] = d;
    prog_we    = 1'b0;
  endtask

  task automatic exit_load();
    prog_en = 1'b0;
    prog_we = 1'b0;
    tick();
    chk("load_mode_exit", {31'b0, load_mode}, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 4))
      0, 1:    a = {20'b0, 10'($urandom_range(0, DEPTH-1)), 2'b00};
      2:       a = {20'b0, 10'($urandom_range(0, DEPTH-1)), 2'($urandom_range(1, 3))};
      3:       a = (32'($urandom_range(1, 7)) * 32'(DEPTH) + 32'($urandom_range(0, DEPTH-1))) << 2;
      default: a = $urandom() | 32'h8000_0000;
    endcase
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    m_held = 1'b0; m_data = ERRW; m_err = 1'b0; m_errcnt = 0;

    // Reset values
    #3;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
    chk("rst_rsp_data",  rsp_data,           ERRW);
    chk("rst_err_cnt",   {16'b0, err_cnt},   32'd0);
    chk("rst_load_mode", {31'b0, load_mode}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("idle_req_ready", {31'b0, req_ready}, 32'd0);
    tick();
    #1;
    chk("run_req_ready", {31'b0, req_ready}, 32'd1);

    // Program every word; the first two are the reference instructions
    enter_load();
    chk("load_req_ready", {31'b0, req_ready}, 32'd0);
    load_write(0, 32'h8C85_0000);
    load_write(1, 32'h10A1_0001);
    for (int unsigned i = 2; i < DEPTH; i++) load_write(i, $urandom());
    exit_load();

    // Back-to-back fetches with latency 1
    step(1'b1, 32'h0, 1'b1);
    chk("b2b_data0", rsp_data, 32'h8C85_0000);
    step(1'b1, 32'h4, 1'b1);
    chk("b2b_data1", rsp_data, 32'h10A1_0001);
    chk("b2b_err1", {31'b0, rsp_err}, 32'd0);
    step(1'b0, 32'h0, 1'b1);

    // Misaligned and out-of-range fetches
    step(1'b1, 32'h6, 1'b1);
    step(1'b1, 32'h800, 1'b1);
    chk("fault_err", {31'b0, rsp_err}, 32'd1);
    chk("fault_cnt", {16'b0, err_cnt}, 32'd2);
    step(1'b0, 32'h0, 1'b1);

    // Backpressure: held response stays stable, no new accept
    step(1'b1, 32'h4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h0, 1'b0);
      chk("hold_data", rsp_data, 32'h10A1_0001);
    end
    step(1'b0, 32'h0, 1'b1);

    // DRAIN: program request while a response is held; writes ignored
    step(1'b1, 32'h0, 1'b0);
    req_valid = 1'b0; rsp_ready = 1'b0;
    prog_en = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_wdata = 32'hDEAD_BEEF;
    #1;
    chk("drain_req_ready", {31'b0, req_ready}, 32'd0);
    tick();
    chk("drain_load_mode0", {31'b0, load_mode}, 32'd0);
    chk("drain_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("drain_rsp_data", rsp_data, m_data);
    tick();
    chk("drain_load_mode1", {31'b0, load_mode}, 32'd0);
    chk("drain_req_ready2", {31'b0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    prog_we = 1'b0;
    m_held = 1'b0;
    chk("drain_to_load", {31'b0, load_mode}, 32'd1);
    chk("drain_consumed", {31'b0, rsp_valid}, 32'd0);
    exit_load();
    step(1'b1, 32'h0, 1'b1);
    chk("drain_mem_kept", rsp_data, 32'h8C85_0000);

    // A word rewritten in LOAD is seen by the first fetch after
    enter_load();
    load_write(7, $urandom());
    exit_load();
    step(1'b1, 32'h1C, 1'b1);
    chk("reload_visible", rsp_data, mem_m[7]);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 3) != 0));
    end

    // Reset in the middle of a held response
    step(1'b1, 32'h4, 1'b1);
    step(1'b1, 32'h6, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_cnt",   {16'b0, err_cnt},   32'd0);
    chk("mid_rst_data",  rsp_data,           ERRW);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
    m_held = 1'b0; m_errcnt = 0;
    tick();
    rst = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
    #1;
    chk("post_rst_idle", {31'b0, req_ready}, 32'd0);
    tick();
    step(1'b1, 32'h0, 1'b1);
    chk("post_rst_mem0", rsp_data, 32'h8C85_0000);
    step(1'b1, 32'h4, 1'b1);
    chk("post_rst_mem1", rsp_data, mem_m[1]);

    // Saturation of the fault counter
    req_valid = 1'b1; req_addr = 32'h6; rsp_ready = 1'b1;
    while (m_errcnt < 65534) begin
      tick();
      model_accept(32'h6);
    end
    chk("sat_pre", {16'b0, err_cnt}, 32'd65534);
    step(1'b1, 32'h6, 1'b1);
    chk("sat_max", {16'b0, err_cnt}, 32'h0000_FFFF);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h800, 1'b1);
    chk("sat_hold", {16'b0, err_cnt}, 32'h0000_FFFF);
    step(1'b0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
